// File: rtl/poly1305_pkg.sv
// Shared Poly1305 definitions: controller state encoding, datapath widths,
// the field prime and the r-clamping helper used when a key is loaded.
package poly1305_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int ACC_WIDTH   = 130;
    localparam int TAG_WIDTH   = 128;

    // Field prime 2^130 - 5, carried one bit wider for the final compare.
    localparam logic [130:0] P1305 = (131'd1 << 130) - 131'd5;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        ABSORB,
        FINAL,
        DONE
    } state_t;

    // Clear the bits of r that Poly1305 requires to be zero.
    function automatic logic [127:0] poly1305_clamp(input logic [127:0] r_in);
        return r_in & 128'h0ffffffc0ffffffc0ffffffc0fffffff;
    endfunction

endpackage

// File: rtl/poly1305_mac_controller_if.sv
// Byte-stream / key / tag bundle of the Poly1305 MAC controller.
// Optional feature macro: POLY1305_MAC_CONTROLLER_BYTE_COUNT_EN adds
// the 32-bit bytes_absorbed counter output.
interface poly1305_mac_controller_if;

    logic [255:0] key;
    logic         start;
    logic [7:0]   data;
    logic         data_valid;
    logic         data_last;
    logic         data_ready;
    logic         busy;
    logic [127:0] tag;
    logic         tag_valid;
`ifdef POLY1305_MAC_CONTROLLER_BYTE_COUNT_EN
    logic [31:0]  bytes_absorbed;
`endif

    modport master (
        output key, start, data, data_valid, data_last,
`ifdef POLY1305_MAC_CONTROLLER_BYTE_COUNT_EN
        input  bytes_absorbed,
`endif
        input  data_ready, busy, tag, tag_valid
    );

    modport slave (
        input  key, start, data, data_valid, data_last,
`ifdef POLY1305_MAC_CONTROLLER_BYTE_COUNT_EN
        output bytes_absorbed,
`endif
        output data_ready, busy, tag, tag_valid
    );

endinterface

// File: rtl/poly1305_block.sv
// Combinational Poly1305 block step: acc' = ((acc + m) * r) mod (2^130 - 5),
// where m is the little-endian block with the 0x01 pad byte placed just
// past the last valid byte. Expects acc < p and returns a fully reduced acc.
module poly1305_block
    import poly1305_pkg::*;
(
    input  logic [BLOCK_BYTES*8-1:0] i_block,
    input  logic [3:0]               i_last_idx,
    input  logic [ACC_WIDTH-1:0]     i_acc,
    input  logic [127:0]             i_r,
    output logic [ACC_WIDTH-1:0]     o_acc
);

    logic [4:0]   w_pad_pos;
    logic [128:0] w_m;
    logic [130:0] w_sum;
    logic [255:0] w_prod;
    logic [130:0] w_fold1;
    logic [130:0] w_fold2;

    // Pad, add, multiply, then fold 2^130 == 5 twice; the result is < 2p,
    // so one conditional subtraction finishes the reduction.
    always_comb begin
        w_pad_pos = {1'b0, i_last_idx} + 5'd1;
        w_m       = {1'b0, i_block} | (129'd1 << {w_pad_pos, 3'b000});
        w_sum     = 131'(i_acc) + 131'(w_m);
        w_prod    = 256'(w_sum) * 256'(i_r);
        w_fold1   = 131'(w_prod[129:0]) + 131'(w_prod[255:130]) * 131'd5;
        w_fold2   = 131'(w_fold1[129:0]) + (w_fold1[130] ? 131'd5 : 131'd0);
        o_acc     = (w_fold2 >= P1305) ? 130'(w_fold2 - P1305) : w_fold2[129:0];
    end

endmodule

// File: rtl/poly1305_mac_controller.sv
// Poly1305 MAC controller: collects message bytes into 16-byte blocks,
// absorbs each block through poly1305_block, then adds s to form the tag.
// Optional feature macro: POLY1305_MAC_CONTROLLER_BYTE_COUNT_EN adds the
// bytes_absorbed transfer counter.
module poly1305_mac_controller
    import poly1305_pkg::*;
(
    input  logic                     clock,
    input  logic                     clear,
    poly1305_mac_controller_if.slave bus
);

    state_t                   r_state;
    logic [ACC_WIDTH-1:0]     r_acc;
    logic [BLOCK_BYTES*8-1:0] r_buf;
    logic [4:0]               r_count;
    logic                     r_last;
    logic [127:0]             r_r;
    logic [127:0]             r_s;
    logic [TAG_WIDTH-1:0]     r_tag;
    logic                     r_tag_valid;

    logic [ACC_WIDTH-1:0]     w_acc_next;
    logic [3:0]               w_last_idx;
    logic                     w_xfer;

    assign w_last_idx = 4'(r_count - 5'd1);
    assign w_xfer     = (r_state == COLLECT) && bus.data_valid;

    poly1305_block u_block (
        .i_block    (r_buf),
        .i_last_idx (w_last_idx),
        .i_acc      (r_acc),
        .i_r        (r_r),
        .o_acc      (w_acc_next)
    );

    // Main FSM: start (re)loads the key and restarts from any state.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_buf       <= '0;
            r_count     <= '0;
            r_last      <= 1'b0;
            r_r         <= '0;
            r_s         <= '0;
            r_tag       <= '0;
            r_tag_valid <= 1'b0;
        end else if (bus.start) begin
            r_state     <= COLLECT;
            r_acc       <= '0;
            r_buf       <= '0;
            r_count     <= '0;
            r_last      <= 1'b0;
            r_r         <= poly1305_clamp(bus.key[127:0]);
            r_s         <= bus.key[255:128];
            r_tag_valid <= 1'b0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (bus.data_valid) begin
                        r_buf[{r_count[3:0], 3'b000} +: 8] <= bus.data;
                        r_count <= r_count + 5'd1;
                        if (r_count == 5'(BLOCK_BYTES - 1) || bus.data_last) begin
                            r_last  <= bus.data_last;
                            r_state <= ABSORB;
                        end
                    end
                end
                ABSORB: begin
                    r_acc   <= w_acc_next;
                    r_buf   <= '0;
                    r_count <= '0;
                    r_state <= r_last ? FINAL : COLLECT;
                end
                FINAL: begin
                    r_tag       <= r_acc[127:0] + r_s;
                    r_tag_valid <= 1'b1;
                    r_state     <= DONE;
                end
                default: r_state <= r_state;
            endcase
        end
    end

`ifdef POLY1305_MAC_CONTROLLER_BYTE_COUNT_EN
    logic [31:0] r_bytes_absorbed;

    // Count every accepted byte of the current message; wraps naturally.
    always_ff @(posedge clock) begin
        if (clear || bus.start) begin
            r_bytes_absorbed <= '0;
        end else if (w_xfer) begin
            r_bytes_absorbed <= r_bytes_absorbed + 32'd1;
        end
    end

    assign bus.bytes_absorbed = r_bytes_absorbed;
`endif

    assign bus.data_ready = (r_state == COLLECT);
    assign bus.busy       = (r_state == COLLECT) || (r_state == ABSORB) || (r_state == FINAL);
    assign bus.tag        = r_tag;
    assign bus.tag_valid  = r_tag_valid;

endmodule

// File: tb/tb_poly1305_mac_controller.sv
// Directed bench for poly1305_mac_controller: RFC 8439 vector, r=0 keys,
// stalled stream, mid-message restart, clear in ABSORB and clear+start.
module tb_poly1305_mac_controller;
    import poly1305_pkg::*;

    localparam logic [255:0] RFC_KEY = {128'h1bf54941aff6bf4afdb20dfb8a800301,
                                        128'ha806d542fe52447f336d555778bed685};
    localparam logic [127:0] RFC_TAG = 128'ha927010caf8b2bc2c6365130c11d06a8;
    localparam logic [127:0] S_SEQ   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] ZR_KEY  = {S_SEQ, 128'h0};

    logic clk = 1'b0;
    logic clear;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic [7:0] msg_buf [0:63];

    bit mon_en = 1'b0;
    int mon_absorb, mon_final, mon_bad;

    poly1305_mac_controller_if bus ();

    poly1305_mac_controller dut (
        .clock (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Watch ABSORB/FINAL occupancy and data_ready while enabled.
    always @(negedge clk) begin
        if (!mon_en) begin
            mon_absorb <= 0;
            mon_final  <= 0;
            mon_bad    <= 0;
        end else begin
            if (dut.r_state == ABSORB) mon_absorb <= mon_absorb + 1;
            if (dut.r_state == FINAL)  mon_final  <= mon_final + 1;
            if ((dut.r_state == ABSORB || dut.r_state == FINAL) && bus.data_ready)
                mon_bad <= mon_bad + 1;
        end
    end

    task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic load_rfc();
        string m;
        m = "Cryptographic Forum Research Group";
        for (int i = 0; i < 34; i++) msg_buf[i] = m[i];
    endtask

    task automatic do_start(input logic [255:0] k, output int c0);
        bus.key   = k;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        c0 = cyc;
    endtask

    // Stream len bytes from msg_buf; optional stall every other cycle.
    task automatic send_msg(input int len, input bit stall, input bit give_last);
        int  i = 0;
        int  guard = 0;
        bit  toggle = 1'b0;
        bit  xfer;
        while (i < len && guard < 500) begin
            bus.data_valid = stall ? toggle : 1'b1;
            toggle         = ~toggle;
            bus.data       = msg_buf[i];
            bus.data_last  = give_last && (i == len - 1);
            @(negedge clk);
            xfer = bus.data_valid && bus.data_ready;
            @(posedge clk); #1;
            if (xfer) i++;
            guard++;
        end
        bus.data_valid = 1'b0;
        bus.data_last  = 1'b0;
        chk("stream_bytes_sent", 256'(i), 256'(len));
    endtask

    task automatic wait_tag(input string name, input int c0, input int exp_lat,
                            input logic [127:0] exp_tag);
        int n = 0;
        while (bus.tag_valid !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_tag_valid"}, 256'(bus.tag_valid), 256'(1'b1));
        chk({name, "_tag"}, 256'(bus.tag), 256'(exp_tag));
        if (exp_lat > 0) chk({name, "_latency"}, 256'(cyc - c0 + 1), 256'(exp_lat));
    endtask

    initial begin
        int c0;
        clear          = 1'b1;
        bus.key        = '0;
        bus.start      = 1'b0;
        bus.data       = '0;
        bus.data_valid = 1'b0;
        bus.data_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clear = 1'b0;

        // Reset state
        chk("rst_tag_valid", 256'(bus.tag_valid), 256'(0));
        chk("rst_tag", 256'(bus.tag), 256'(0));
        chk("rst_busy", 256'(bus.busy), 256'(0));
        chk("rst_ready", 256'(bus.data_ready), 256'(0));
        chk("rst_state", 256'(dut.r_state), 256'(IDLE));

        // RFC 8439 2.5.2, unstalled
        load_rfc();
        do_start(RFC_KEY, c0);
        chk("rfc_busy", 256'(bus.busy), 256'(1));
        send_msg(34, 1'b0, 1'b1);
        wait_tag("rfc", c0, 39, RFC_TAG);
`ifdef POLY1305_MAC_CONTROLLER_BYTE_COUNT_EN
        chk("rfc_bytes_absorbed", 256'(bus.bytes_absorbed), 256'(34));
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rfc_tag_hold", 256'(bus.tag_valid), 256'(1));
        chk("rfc_done_busy", 256'(bus.busy), 256'(0));

        // r = 0: tag equals s; 1-byte then 16-byte messages
        msg_buf[0] = 8'hAA;
        do_start(ZR_KEY, c0);
        chk("zr1_tag_valid_drop", 256'(bus.tag_valid), 256'(0));
        send_msg(1, 1'b0, 1'b1);
        wait_tag("zr1", c0, 4, S_SEQ);
        for (int i = 0; i < 16; i++) msg_buf[i] = 8'(i * 7 + 3);
        do_start(ZR_KEY, c0);
        send_msg(16, 1'b0, 1'b1);
        wait_tag("zr16", c0, 19, S_SEQ);

        // RFC vector with data_valid low every other cycle
        load_rfc();
        do_start(RFC_KEY, c0);
        mon_en = 1'b1;
        send_msg(34, 1'b1, 1'b1);
        wait_tag("stall", c0, 0, RFC_TAG);
        @(posedge clk); #1;
        mon_en = 1'b0;
        chk("stall_absorb_cycles", 256'(mon_absorb), 256'(3));
        chk("stall_final_cycles", 256'(mon_final), 256'(1));
        chk("stall_ready_in_absorb_final", 256'(mon_bad), 256'(0));

        // Restart mid-message after 20 junk bytes
        for (int i = 0; i < 20; i++) msg_buf[i] = 8'(8'hF0 ^ i);
        do_start(RFC_KEY, c0);
        send_msg(20, 1'b0, 1'b0);
        load_rfc();
        do_start(RFC_KEY, c0);
        send_msg(34, 1'b0, 1'b1);
        wait_tag("abort", c0, 39, RFC_TAG);

        // clear while in ABSORB (tag currently holds the RFC tag)
        do_start(RFC_KEY, c0);
        send_msg(16, 1'b0, 1'b0);
        chk("clr_pre_state", 256'(dut.r_state), 256'(ABSORB));
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clr_state", 256'(dut.r_state), 256'(IDLE));
        chk("clr_tag", 256'(bus.tag), 256'(0));
        chk("clr_tag_valid", 256'(bus.tag_valid), 256'(0));
        chk("clr_busy", 256'(bus.busy), 256'(0));
        chk("clr_ready", 256'(bus.data_ready), 256'(0));
        chk("clr_acc", 256'(dut.r_acc), 256'(0));

        // clear together with start: clear wins
        bus.key   = RFC_KEY;
        bus.start = 1'b1;
        clear     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        clear     = 1'b0;
        chk("clrst_state", 256'(dut.r_state), 256'(IDLE));
        chk("clrst_r", 256'(dut.r_r), 256'(0));
        chk("clrst_busy", 256'(bus.busy), 256'(0));
        chk("clrst_ready", 256'(bus.data_ready), 256'(0));

        // Recovery after clear
        load_rfc();
        do_start(RFC_KEY, c0);
        send_msg(34, 1'b0, 1'b1);
        wait_tag("recover", c0, 39, RFC_TAG);
`ifdef POLY1305_MAC_CONTROLLER_BYTE_COUNT_EN
        chk("recover_bytes_absorbed", 256'(bus.bytes_absorbed), 256'(34));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/poly1305_mac_controller.md
POLY1305_MAC_CONTROLLER -- requirements
Module: poly1305_mac_controller

Interface
REQ-001 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port clear, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port key, input, 256 bits: bits [127:0] are r (unclamped), bits [255:128] are s; sampled only on an accepted start.
REQ-004 SHALL have port start, input, 1 bit: a one-cycle pulse that begins a new message.
REQ-005 SHALL have port data, input, 8 bits: one message byte.
REQ-006 SHALL have port data_valid, input, 1 bit: the data byte is present.
REQ-007 SHALL have port data_last, input, 1 bit: qualified by data_valid; marks the final message byte.
REQ-008 SHALL have port data_ready, output, 1 bit: a byte transfers when data_valid and data_ready are both high.
REQ-009 SHALL have port busy, output, 1 bit: high in COLLECT, ABSORB and FINAL.
REQ-010 SHALL have port tag, output, 128 bits: the computed Poly1305 tag.
REQ-011 SHALL have port tag_valid, output, 1 bit: tag is valid; held high until the next start or clear.

Function
REQ-012 SHALL implement states IDLE, COLLECT, ABSORB, FINAL, DONE.
REQ-013 On start in any state, SHALL:
- register clamp(key[127:0]) and key[255:128];
- zero the 130-bit accumulator, the byte count and the block buffer;
- drop tag_valid;
- enter COLLECT the next cycle.
An in-flight message is abandoned.
REQ-014 SHALL drive data_ready high only in COLLECT; data_valid is ignored in all other states.
REQ-015 In COLLECT, each transferred byte SHALL be written to buffer bits [8*count+7:8*count] (little-endian), and count SHALL increment.
REQ-016 SHALL move COLLECT -> ABSORB on the transfer that makes count 16, or on any transfer with data_last high, recording the data_last flag.
REQ-017 In ABSORB, for exactly one cycle, SHALL:
- set acc <= poly1305_block(buffer, count-1, acc, r);
- clear the buffer and count;
- go to FINAL if last was recorded, else to COLLECT.
REQ-018 In FINAL, SHALL register tag <= (acc[127:0] + s) mod 2^128, set tag_valid, and go to DONE.
REQ-019 DONE SHALL hold tag and tag_valid until start or clear.
REQ-020 Messages SHALL contain at least one byte; an empty message is unsupported.
REQ-021 Latency: with an unstalled byte stream beginning the cycle after start, tag_valid SHALL rise N + ceil(N/16) + 2 cycles after start for an N-byte message (N=16 gives 19).
REQ-022 Stalls (data_valid low) SHALL only extend latency and SHALL NOT change the tag.

Reset
REQ-023 On clear, SHALL reset to:
- state IDLE;
- accumulator, buffer, count, r, s and tag all zero;
- tag_valid, busy and data_ready all 0.
REQ-024 clear SHALL take priority over a simultaneous start.

Configuration
REQ-025 With POLY1305_MAC_CONTROLLER_BYTE_COUNT_EN defined, SHALL add output bytes_absorbed (32 bits):
- zeroed on clear and on start;
- incremented on each byte transfer;
- wraps at 2^32;
- valid alongside tag.
REQ-026 Without POLY1305_MAC_CONTROLLER_BYTE_COUNT_EN, that port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 SHALL take the following from shared package poly1305_pkg:
- the state enum;
- BLOCK_BYTES=16, ACC_WIDTH=130, TAG_WIDTH=128.
REQ-028 SHALL instantiate the existing combinational poly1305_block as its single sub-module, and reuse the existing poly1305_clamp for r.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
- RFC 8439 2.5.2 key and 34-byte "Cryptographic Forum Research Group", unstalled -> tag a8061dc1305136c6c22b8baf0c0127a9, tag_valid at cycle 34+3+2=39.
- Key r=0, s=0x000102...0f, 1-byte message 0xAA -> tag = s; 16-byte message -> tag = s at cycle 19.
- RFC vector with data_valid low every other cycle -> same tag; data_ready low throughout ABSORB and FINAL.
- start asserted mid-message after 20 bytes, then the full RFC message -> RFC tag; no residue from the aborted message.
- clear in ABSORB and clear together with start -> all outputs zero, state IDLE; a following start and message gives the correct tag.
- With BYTE_COUNT_EN, the 34-byte message -> bytes_absorbed = 34.
